// File: rtl/dragon_pkg.sv
// Shared definitions for the player dragon's vertical motion.
// Holds the jump FSM state type and default geometry/timing constants. The renderer and the
// collision logic use the same constants so that all three blocks agree on ground and apex
// positions.
package dragon_pkg;

    typedef enum logic [1:0] {
        StGround,
        StRise,
        StHang,
        StFall
    } jump_state_t;

    localparam int unsigned GROUND_Y_DEF    = 400;
    localparam int unsigned JUMP_HEIGHT_DEF = 120;
    localparam int unsigned STEP_DEF        = 4;
    localparam int unsigned HANG_TICKS_DEF  = 8;
    localparam int unsigned Y_W_DEF         = 10;

endpackage

// File: rtl/btn_sync_edge.sv
// Button conditioner: 2-flop synchronizer followed by a registered rising-edge pulse.
// Ports:
//   clk_i   - clock of the receiving domain
//   rst_ni  - synchronous active-low reset; all flops clear to 0
//   btn_i   - raw button level, asynchronous to clk_i
//   rise_o  - one-cycle pulse, high 3 cycles after btn_i rises
module btn_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic rise_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic rise_q,  rise_d;

    always_comb begin
        sync1_d = btn_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        rise_d  = sync2_q & ~prev_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/dragon_jump.sv
// Vertical-motion controller for the player dragon.
// A jump button press launches a rise / hang / fall trajectory that advances one step per
// frame tick.
// Ports:
//   pixel_clk - sole clock
//   rst_n     - synchronous active-low reset
//   update    - one-cycle frame tick; may be held high for consecutive cycles
//   jump_btn  - raw button level, asynchronous to pixel_clk
//   dragon_y  - registered top-edge Y of the dragon, always within [APEX, GROUND_Y]
//   airborne  - registered, high while rising, hanging or falling
//   landed    - registered one-cycle pulse alongside the return to GROUND_Y
module dragon_jump
    import dragon_pkg::*;
#(
    parameter int unsigned GROUND_Y    = GROUND_Y_DEF,
    parameter int unsigned JUMP_HEIGHT = JUMP_HEIGHT_DEF,
    parameter int unsigned STEP        = STEP_DEF,
    parameter int unsigned HANG_TICKS  = HANG_TICKS_DEF,
    parameter int unsigned Y_W         = Y_W_DEF
) (
    input  logic           pixel_clk,
    input  logic           rst_n,
    input  logic           update,
    input  logic           jump_btn,
    output logic [Y_W-1:0] dragon_y,
    output logic           airborne,
    output logic           landed
);

    localparam int unsigned APEX  = GROUND_Y - JUMP_HEIGHT;
    localparam int unsigned CNT_W = $clog2(HANG_TICKS + 1);

    localparam logic [Y_W:0]     GROUND_X  = (Y_W + 1)'(GROUND_Y);
    localparam logic [Y_W:0]     APEX_X    = (Y_W + 1)'(APEX);
    localparam logic [Y_W:0]     STEP_X    = (Y_W + 1)'(STEP);
    localparam logic [CNT_W-1:0] LAST_HANG = CNT_W'(HANG_TICKS - 1);

    jump_state_t      state_q, state_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [CNT_W-1:0] hang_cnt_q, hang_cnt_d;
    logic             pending_q, pending_d;
    logic             airborne_q, airborne_d;
    logic             landed_q, landed_d;

    logic             btn_rise;
    logic             go_up;
    logic [Y_W:0]     y_dec, y_inc;

    btn_sync_edge u_btn_sync_edge (
        .clk_i  (pixel_clk),
        .rst_ni (rst_n),
        .btn_i  (jump_btn),
        .rise_o (btn_rise)
    );

    always_comb begin
        state_d    = state_q;
        y_d        = y_q;
        hang_cnt_d = hang_cnt_q;
        pending_d  = pending_q;
        airborne_d = airborne_q;
        landed_d   = 1'b0;
        go_up      = 1'b0;

        // One extra bit: bit Y_W of y_dec flags a borrow, y_inc cannot overflow.
        y_dec = {1'b0, y_q} - STEP_X;
        y_inc = {1'b0, y_q} + STEP_X;

        // Presses in the air are dropped and also cancel anything still pending.
        if (btn_rise) begin
            pending_d = (state_q == StGround);
        end

        if (update) begin
            case (state_q)
                StGround: begin
                    // A press arriving with this very tick counts as pending.
                    if (pending_q || btn_rise) begin
                        go_up     = 1'b1;
                        pending_d = 1'b0;
                    end
                end
                StRise: go_up = 1'b1;
                StHang: begin
                    hang_cnt_d = hang_cnt_q + 1'b1;
                    if (hang_cnt_q == LAST_HANG) begin
                        state_d = StFall;
                    end
                end
                StFall: begin
                    if (y_inc >= GROUND_X) begin
                        y_d        = Y_W'(GROUND_Y);
                        state_d    = StGround;
                        airborne_d = 1'b0;
                        landed_d   = 1'b1;
                    end else begin
                        y_d = y_inc[Y_W-1:0];
                    end
                end
                default: state_d = StGround;
            endcase
        end

        // Launch and rise share one step so that the very first step can already clamp.
        if (go_up) begin
            airborne_d = 1'b1;
            if (y_dec[Y_W] || (y_dec <= APEX_X)) begin
                y_d        = Y_W'(APEX);
                hang_cnt_d = '0;
                state_d    = StHang;
            end else begin
                y_d     = y_dec[Y_W-1:0];
                state_d = StRise;
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            state_q    <= StGround;
            y_q        <= Y_W'(GROUND_Y);
            hang_cnt_q <= '0;
            pending_q  <= 1'b0;
            airborne_q <= 1'b0;
            landed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            y_q        <= y_d;
            hang_cnt_q <= hang_cnt_d;
            pending_q  <= pending_d;
            airborne_q <= airborne_d;
            landed_q   <= landed_d;
        end
    end

    assign dragon_y = y_q;
    assign airborne = airborne_q;
    assign landed   = landed_q;

    // APEX_X is only consulted through the clamp compare above.
    logic unused_apex;
    assign unused_apex = ^APEX_X;

endmodule

// File: tb/tb_dragon_jump.sv
// Self-checking bench for dragon_jump.
// Two instances share clock, reset and update: dut_d uses default geometry, dut_c uses a
// 10-pixel jump height to exercise the apex clamp. Expected per-tick outputs are queued when a
// jump is launched and popped on each tick; with an empty queue the dragon must be at rest.
module tb_dragon_jump;

    typedef struct packed {
        logic [9:0] y;
        logic       air;
        logic       land;
    } exp_t;

    localparam exp_t IDLE = '{y: 10'd400, air: 1'b0, land: 1'b0};

    logic       clk;
    logic       rst_n;
    logic       update;
    logic       jump_btn;
    logic       c_btn;
    logic [9:0] dragon_y;
    logic       airborne;
    logic       landed;
    logic [9:0] c_dragon_y;
    logic       c_airborne;
    logic       c_landed;

    exp_t sb_d[$];
    exp_t sb_c[$];
    exp_t last_d;
    exp_t last_c;
    int   push_left;
    int   checks;
    int   errors;

    dragon_jump dut_d (
        .pixel_clk (clk),
        .rst_n     (rst_n),
        .update    (update),
        .jump_btn  (jump_btn),
        .dragon_y  (dragon_y),
        .airborne  (airborne),
        .landed    (landed)
    );

    dragon_jump #(
        .JUMP_HEIGHT (10)
    ) dut_c (
        .pixel_clk (clk),
        .rst_n     (rst_n),
        .update    (update),
        .jump_btn  (c_btn),
        .dragon_y  (c_dragon_y),
        .airborne  (c_airborne),
        .landed    (c_landed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_one(input bit to_c, input int y, input bit air, input bit land);
        exp_t e;
        if (push_left > 0) begin
            e.y    = 10'(y);
            e.air  = air;
            e.land = land;
            if (to_c) sb_c.push_back(e);
            else      sb_d.push_back(e);
            push_left--;
        end
    endtask

    // Expected trajectory for a jump from 400 with step 4 and 8 hang ticks.
    task automatic push_traj(input bit to_c, input int apex, input int max_ticks);
        int y;
        y         = 400;
        push_left = max_ticks;
        do begin
            y -= 4;
            if (y < apex) y = apex;
            push_one(to_c, y, 1'b1, 1'b0);
        end while (y != apex);
        repeat (8) push_one(to_c, apex, 1'b1, 1'b0);
        while (y != 400) begin
            y += 4;
            if (y > 400) y = 400;
            push_one(to_c, y, y != 400, y == 400);
        end
    endtask

    task automatic check_out(input bit upd);
        if (upd) begin
            if (sb_d.size() > 0) last_d = sb_d.pop_front();
            else                 last_d = IDLE;
            if (sb_c.size() > 0) last_c = sb_c.pop_front();
            else                 last_c = IDLE;
        end else begin
            last_d.land = 1'b0;
            last_c.land = 1'b0;
        end
        chk("dflt_y",        32'(dragon_y),   32'(last_d.y));
        chk("dflt_airborne", 32'(airborne),   32'(last_d.air));
        chk("dflt_landed",   32'(landed),     32'(last_d.land));
        chk("clamp_y",       32'(c_dragon_y), 32'(last_c.y));
        chk("clamp_airborne",32'(c_airborne), 32'(last_c.air));
        chk("clamp_landed",  32'(c_landed),   32'(last_c.land));
    endtask

    // Called at a negedge: drive update, let one posedge pass, check at the next negedge.
    task automatic cyc(input bit upd);
        update = upd;
        @(negedge clk);
        check_out(upd);
    endtask

    task automatic tick(input int gap);
        repeat (gap - 1) cyc(1'b0);
        cyc(1'b1);
    endtask

    task automatic reset_one_cycle();
        rst_n  = 1'b0;
        update = 1'b1;
        @(negedge clk);
        last_d = IDLE;
        last_c = IDLE;
        sb_d.delete();
        sb_c.delete();
        check_out(1'b0);
        rst_n  = 1'b1;
        update = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        update   = 1'b0;
        jump_btn = 1'b0;
        c_btn    = 1'b0;
        last_d   = IDLE;
        last_c   = IDLE;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check_out(1'b0);
        rst_n = 1'b1;
        cyc(1'b0);

        // Single default jump, tick every 16 cycles; a second press during HANG is dropped
        // and the dragon must stay grounded for 10 ticks after landing.
        jump_btn = 1'b1;
        push_traj(1'b0, 280, 1000);
        for (int t = 1; t <= 78; t++) begin
            tick(16);
            if (t == 6)  jump_btn = 1'b0;
            if (t == 32) jump_btn = 1'b1;
            if (t == 34) jump_btn = 1'b0;
        end

        // Apex clamp with a 10-pixel jump: 396, 392, 390, hang, 394, 398, 400.
        c_btn = 1'b1;
        push_traj(1'b1, 390, 1000);
        for (int t = 1; t <= 18; t++) begin
            tick(4);
            if (t == 2) c_btn = 1'b0;
        end

        // Edge and update in the same cycle, then update held high: one step per cycle.
        jump_btn = 1'b1;
        push_traj(1'b0, 280, 1000);
        repeat (3) cyc(1'b0);
        for (int t = 1; t <= 72; t++) begin
            cyc(1'b1);
            if (t == 10) jump_btn = 1'b0;
        end
        cyc(1'b0);

        // Reset mid-fall at y = 340 (tick 53 with back-to-back updates).
        jump_btn = 1'b1;
        push_traj(1'b0, 280, 53);
        repeat (3) cyc(1'b0);
        for (int t = 1; t <= 53; t++) begin
            cyc(1'b1);
            if (t == 5) jump_btn = 1'b0;
        end
        chk("pre_reset_y", 32'(dragon_y), 32'd340);
        reset_one_cycle();
        repeat (10) tick(4);

        // A pending press captured in GROUND must not survive reset.
        jump_btn = 1'b1;
        repeat (6) cyc(1'b0);
        jump_btn = 1'b0;
        reset_one_cycle();
        repeat (5) tick(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dragon_jump.md
# dragon_jump

Vertical-motion controller for the player dragon. It sits downstream of the frame-rate tick generator and consumes its one-cycle `update` pulse, which is the receiving end of that tick. It turns a jump button press into a rise / hang / fall trajectory, advancing one step per tick. Its Y coordinate output feeds the sprite renderer and the collision logic in the `pixel_clk` domain.

## Interface
- `GROUND_Y`, 400: resting Y (screen pixels, top = 0).
- `JUMP_HEIGHT`, 120: apex distance above ground; must be ≥ 1 and ≤ `GROUND_Y`.
- `STEP`, 4: pixels moved per tick; must be ≥ 1.
- `HANG_TICKS`, 8: ticks held at apex; must be ≥ 1.
- `Y_W`, 10: width of the Y coordinate.
- `pixel_clk`  in  1  sole clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `update`  in  1  one-cycle tick from the tick generator; back-to-back assertion is legal.
- `jump_btn`  in  1  raw button level, asynchronous to `pixel_clk`.
- `dragon_y`  out  `Y_W`  current top-edge Y of the dragon.
- `airborne`  out  1  high in RISE, HANG and FALL.
- `landed`  out  1  one-cycle pulse on return to GROUND.

## Operation
- `jump_btn` passes through a 2-flop synchronizer, then a rising-edge detect. An edge sets `pending`.
- `pending` is cleared in three cases:
  - when it is consumed;
  - on any edge that arrives while not in GROUND, so presses made in the air are dropped, with no buffered double jump;
  - on reset.
- An edge and `update` in the same cycle while in GROUND counts as pending for that tick: the jump starts on that tick.
- FSM states GROUND, RISE, HANG, FALL. State changes only on `update` cycles:
  - GROUND with `pending`: go to RISE; `y ← GROUND_Y − STEP`, clamped; clear `pending`.
  - RISE: `y ← y − STEP`. If the result is ≤ `APEX = GROUND_Y − JUMP_HEIGHT`, then `y ← APEX`, `hang_cnt ← 0`, go to HANG. The first RISE step itself applies this clamp.
  - HANG: `hang_cnt ← hang_cnt + 1`. When `hang_cnt == HANG_TICKS − 1`, go to FALL. HANG therefore spans exactly `HANG_TICKS` ticks.
  - FALL: `y ← y + STEP`. If the result is ≥ `GROUND_Y`, then `y ← GROUND_Y`, go to GROUND, and pulse `landed`.
- Arithmetic is done in `Y_W + 1` bits so clamps never wrap; `dragon_y` never leaves [`APEX`, `GROUND_Y`].
- The `hang_cnt` width is `$clog2(HANG_TICKS + 1)`.

## Timing
- Reset values:
  - `dragon_y = GROUND_Y`
  - `airborne = 0`
  - `landed = 0`
  - state = GROUND
  - `pending = 0`
  - synchronizer flops = 0
- All outputs are registered. `dragon_y` and `airborne` change in the cycle after the `update` that causes the change.
- `landed` is high for exactly one cycle, aligned with the `dragon_y = GROUND_Y` update.
- Button latency: an edge is visible to the FSM 3 cycles after `jump_btn` rises (2 sync flops plus edge register). The jump starts on the first `update` at or after that point.
- Cycles without `update` hold all state, except the synchronizer and `pending`.
- Reset mid-jump: in the cycle after `rst_n` is sampled low, `dragon_y = GROUND_Y`, state = GROUND, and `landed` stays 0, with no landing pulse on reset.
- Tick count for a full jump with defaults: RISE 30 + HANG 8 + FALL 30 = 68 ticks, `landed` on tick 68.

## Structure
- The shared package `dragon_pkg` holds:
  - the `jump_state_t` enum (GROUND, RISE, HANG, FALL);
  - default constants `GROUND_Y_DEF`, `JUMP_HEIGHT_DEF`, `STEP_DEF`, `HANG_TICKS_DEF`, `Y_W_DEF`, shared with the renderer and the collision logic.
- One sub-module, `btn_sync_edge`: the 2-flop synchronizer plus rising-edge pulse, reusable for other buttons.
- The FSM, Y register, hang counter and `pending` live in `dragon_jump`.

## Test plan
- **Single jump, defaults, `update` every 16 cycles:**
  - Press held 100 cycles; `dragon_y` steps 396, 392, … 280.
  - `dragon_y` holds 280 for 8 ticks, then 284 … 400.
  - `landed` pulses once; `airborne` is high for 68 ticks total.
- **Clamp:** `JUMP_HEIGHT = 10`, `STEP = 4` → rise 396, 392, 390; HANG; fall 394, 398, 400. Y is never below 390.
- **Air press dropped:** press again during HANG → no second jump; after landing, `dragon_y` stays 400 across 10 further ticks.
- **Simultaneous:** an edge arriving in the same cycle as `update` in GROUND → `dragon_y` = 396 in the next cycle.
- **Back-to-back ticks:** `update` held high continuously → one step per cycle; full jump completes in 68 cycles.
- **Reset mid-fall:** at `dragon_y` = 340, `rst_n = 0` for 1 cycle → next cycle `dragon_y` = 400, `airborne` = 0, `landed` = 0, `pending` = 0.
